// File: rtl/sbox_share_ctrl.sv
// Time-shares four AES byte S-boxes between SubBytes (128-bit, four column beats)
// and SubWord (32-bit, one beat), arbitrating round-robin at job boundaries.
module sbox_share_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  input  logic [127:0] data_in,
  output logic         data_out_valid,
  output logic [127:0] data_out,
  input  logic         key_in_valid,
  output logic         key_in_ready,
  input  logic [31:0]  key_in,
  output logic         key_out_valid,
  output logic [31:0]  key_out,
  output logic         busy
);

  localparam int unsigned COL_W  = 32;
  localparam int unsigned N_LANE = 4;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned BUF_W  = DATA_W - COL_W;

  localparam logic [7:0] SBOX_LUT [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, DATA_RUN, KEY_RUN} state_t;
  typedef enum logic {GRANT_DATA, GRANT_KEY} grant_t;

  state_t              state_q;
  grant_t              last_grant_q;
  logic [1:0]          beat_q;
  logic [DATA_W-1:0]   in_buf_q;
  logic [BUF_W-1:0]    out_buf_q;
  logic [COL_W-1:0]    key_buf_q;
  logic [DATA_W-1:0]   data_out_q;
  logic [COL_W-1:0]    key_out_q;
  logic                data_out_valid_q;
  logic                key_out_valid_q;
  logic                busy_q;

  logic [COL_W-1:0]    col_sel;
  logic [COL_W-1:0]    sbox_in;
  logic [COL_W-1:0]    sbox_out;
  logic                data_acc;
  logic                key_acc;

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign key_out        = key_out_q;
  assign key_out_valid  = key_out_valid_q;
  assign busy           = busy_q;

  // Readies: only in IDLE out of reset; on a tie only the round-robin winner sees ready.
  always_comb begin
    data_in_ready = 1'b0;
    key_in_ready  = 1'b0;
    if (!rst && state_q == IDLE) begin
      data_in_ready = !(key_in_valid && last_grant_q == GRANT_DATA);
      key_in_ready  = !(data_in_valid && last_grant_q == GRANT_KEY);
    end
  end

  assign data_acc = data_in_valid && data_in_ready;
  assign key_acc  = key_in_valid && key_in_ready;

  // Column select for the current data beat, or the latched key word.
  always_comb begin
    col_sel = in_buf_q[31:0];
    case (beat_q)
      2'd0: col_sel = in_buf_q[31:0];
      2'd1: col_sel = in_buf_q[63:32];
      2'd2: col_sel = in_buf_q[95:64];
      2'd3: col_sel = in_buf_q[127:96];
      default: col_sel = in_buf_q[31:0];
    endcase
    sbox_in = (state_q == KEY_RUN) ? key_buf_q : col_sel;
  end

  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    assign sbox_out[8*i +: 8] = SBOX_LUT[sbox_in[8*i +: 8]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_q     <= GRANT_DATA;
      beat_q           <= 2'd0;
      in_buf_q         <= '0;
      out_buf_q        <= '0;
      key_buf_q        <= '0;
      data_out_q       <= '0;
      key_out_q        <= '0;
      data_out_valid_q <= 1'b0;
      key_out_valid_q  <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      data_out_valid_q <= 1'b0;
      key_out_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_acc) begin
            in_buf_q <= data_in;
            beat_q   <= 2'd0;
            state_q  <= DATA_RUN;
            busy_q   <= 1'b1;
          end else if (key_acc) begin
            key_buf_q <= key_in;
            state_q   <= KEY_RUN;
            busy_q    <= 1'b1;
          end
        end
        DATA_RUN: begin
          beat_q <= beat_q + 2'd1;
          case (beat_q)
            2'd0: out_buf_q[31:0]  <= sbox_out;
            2'd1: out_buf_q[63:32] <= sbox_out;
            2'd2: out_buf_q[95:64] <= sbox_out;
            default: begin
              // Last column goes straight to the output alongside the buffered three.
              data_out_q       <= {sbox_out, out_buf_q};
              data_out_valid_q <= 1'b1;
              last_grant_q     <= GRANT_DATA;
              state_q          <= IDLE;
              busy_q           <= 1'b0;
            end
          endcase
        end
        KEY_RUN: begin
          key_out_q       <= sbox_out;
          key_out_valid_q <= 1'b1;
          last_grant_q    <= GRANT_KEY;
          state_q         <= IDLE;
          busy_q          <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: latency, lane order, round-robin, mid-job key wait, reset abort.
module tb_sbox_share_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         data_in_valid = 1'b0;
  logic         data_in_ready;
  logic [127:0] data_in = '0;
  logic         data_out_valid;
  logic [127:0] data_out;
  logic         key_in_valid = 1'b0;
  logic         key_in_ready;
  logic [31:0]  key_in = '0;
  logic         key_out_valid;
  logic [31:0]  key_out;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  sbox_share_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_in        (data_in),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .key_in_valid   (key_in_valid),
    .key_in_ready   (key_in_ready),
    .key_in         (key_in),
    .key_out_valid  (key_out_valid),
    .key_out        (key_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; data_in_valid = 1'b1; key_in_valid = 1'b1;
    repeat (2) step();
    n_checks++; if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_data_ready: got %b want 0", data_in_ready); end
    n_checks++; if (key_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_key_ready: got %b want 0", key_in_ready); end
    n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL rst_data_out: got %h want 0", data_out); end
    n_checks++; if (key_out !== 32'h0) begin n_fail++; $display("FAIL rst_key_out: got %h want 0", key_out); end
    n_checks++; if ({data_out_valid, key_out_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {data_out_valid, key_out_valid, busy}); end
    data_in_valid = 1'b0; key_in_valid = 1'b0; rst = 1'b0;
    #1;
    n_checks++; if ({data_in_ready, key_in_ready} !== 2'b11) begin n_fail++; $display("FAIL idle_readies: got %b want 11", {data_in_ready, key_in_ready}); end
    step();
    n_checks++; if ({data_out_valid, key_out_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL idle_flags: got %b want 000", {data_out_valid, key_out_valid, busy}); end
  endtask

  task automatic test_data(input logic [127:0] din, input logic [127:0] exp, input string nm);
    data_in = din; data_in_valid = 1'b1;
    #1;
    n_checks++; if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b want 1", nm, data_in_ready); end
    step();
    data_in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy0: got %b want 1", nm, busy); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++; if (data_out_valid !== (k == 4)) begin n_fail++; $display("FAIL %s_valid_k%0d: got %b want %b", nm, k, data_out_valid, (k == 4)); end
      n_checks++; if (busy !== (k < 4)) begin n_fail++; $display("FAIL %s_busy_k%0d: got %b want %b", nm, k, busy, (k < 4)); end
      n_checks++; if (key_out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_keyvalid_k%0d: got %b want 0", nm, k, key_out_valid); end
    end
    n_checks++; if (data_out !== exp) begin n_fail++; $display("FAIL %s_out: got %h want %h", nm, data_out, exp); end
    step();
    n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: got %b want 0", nm, data_out_valid); end
    n_checks++; if (data_out !== exp) begin n_fail++; $display("FAIL %s_hold: got %h want %h", nm, data_out, exp); end
  endtask

  task automatic test_key(input logic [31:0] kin, input logic [31:0] exp, input logic [127:0] dhold, input string nm);
    key_in = kin; key_in_valid = 1'b1;
    #1;
    n_checks++; if (key_in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b want 1", nm, key_in_ready); end
    step();
    key_in_valid = 1'b0;
    n_checks++; if ({key_out_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL %s_run: got %b want 01", nm, {key_out_valid, busy}); end
    step();
    n_checks++; if ({key_out_valid, busy, data_out_valid} !== 3'b100) begin n_fail++; $display("FAIL %s_done: got %b want 100", nm, {key_out_valid, busy, data_out_valid}); end
    n_checks++; if (key_out !== exp) begin n_fail++; $display("FAIL %s_out: got %h want %h", nm, key_out, exp); end
    n_checks++; if (data_out !== dhold) begin n_fail++; $display("FAIL %s_data_hold: got %h want %h", nm, data_out, dhold); end
    step();
    n_checks++; if (key_out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: got %b want 0", nm, key_out_valid); end
  endtask

  task automatic test_tie_rr();
    logic [1:0] want [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
    rst = 1'b1; step(); rst = 1'b0;
    key_in = 32'h00000000; data_in = {16{8'h01}};
    for (int r = 0; r < 3; r++) begin
      if (r == 2) key_in = 32'hffffffff;
      data_in_valid = 1'b1; key_in_valid = 1'b1;
      #1;
      n_checks++; if ({data_in_ready, key_in_ready} !== want[r]) begin n_fail++; $display("FAIL tie%0d_grant: got %b want %b", r, {data_in_ready, key_in_ready}, want[r]); end
      step();
      data_in_valid = 1'b0; key_in_valid = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tie%0d_busy: got %b want 1", r, busy); end
      if (r == 1) begin
        repeat (3) begin
          step();
          n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tie1_busy_run: got %b want 1", busy); end
        end
      end
      step();
      n_checks++; if ({data_out_valid, key_out_valid, busy} !== {want[r], 1'b0}) begin n_fail++; $display("FAIL tie%0d_done: got %b want %b", r, {data_out_valid, key_out_valid, busy}, {want[r], 1'b0}); end
    end
    n_checks++; if (key_out !== 32'h16161616) begin n_fail++; $display("FAIL tie_key_out: got %h want 16161616", key_out); end
    n_checks++; if (data_out !== {16{8'h7c}}) begin n_fail++; $display("FAIL tie_data_out: got %h want %h", data_out, {16{8'h7c}}); end
    step();
  endtask

  task automatic test_key_during_data();
    data_in = {16{8'hff}}; data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    step();
    key_in = 32'h01020304; key_in_valid = 1'b1;
    #1;
    n_checks++; if (key_in_ready !== 1'b0) begin n_fail++; $display("FAIL kdd_ready_b1: got %b want 0", key_in_ready); end
    for (int b = 2; b <= 3; b++) begin
      step();
      n_checks++; if (key_in_ready !== 1'b0) begin n_fail++; $display("FAIL kdd_ready_b%0d: got %b want 0", b, key_in_ready); end
    end
    step();
    n_checks++; if ({data_out_valid, key_in_ready} !== 2'b11) begin n_fail++; $display("FAIL kdd_idle: got %b want 11", {data_out_valid, key_in_ready}); end
    n_checks++; if (data_out !== {16{8'h16}}) begin n_fail++; $display("FAIL kdd_data_out: got %h want %h", data_out, {16{8'h16}}); end
    step();
    key_in_valid = 1'b0;
    n_checks++; if ({key_out_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL kdd_key_run: got %b want 01", {key_out_valid, busy}); end
    step();
    n_checks++; if (key_out_valid !== 1'b1) begin n_fail++; $display("FAIL kdd_key_valid: got %b want 1", key_out_valid); end
    n_checks++; if (key_out !== 32'h7c777bf2) begin n_fail++; $display("FAIL kdd_key_out: got %h want 7c777bf2", key_out); end
    step();
  endtask

  task automatic test_reset_mid_job();
    data_in = 128'h0; data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    n_checks++; if ({data_out_valid, key_out_valid, busy, data_in_ready, key_in_ready} !== 5'b0) begin n_fail++; $display("FAIL rmj_flags: got %b want 00000", {data_out_valid, key_out_valid, busy, data_in_ready, key_in_ready}); end
    n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL rmj_data_out: got %h want 0", data_out); end
    n_checks++; if (key_out !== 32'h0) begin n_fail++; $display("FAIL rmj_key_out: got %h want 0", key_out); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if ({data_out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rmj_quiet%0d: got %b want 00", k, {data_out_valid, busy}); end
    end
    test_key(32'h53ff0001, 32'hed16637c, 128'h0, "rmj_key");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_data(128'h0, {16{8'h63}}, "data_zero");
    test_key(32'h01020304, 32'h7c777bf2, {16{8'h63}}, "key_basic");
    test_data(128'h53ff0001_02030405_06070809_0a0b0c0d,
              128'hed16637c_777bf26b_6fc53001_672bfed7, "data_order");
    test_tie_rr();
    test_key_during_data();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (data_out_valid && key_out_valid) begin
      n_fail++;
      $display("FAIL dual_pulse: got data_out_valid=1 key_out_valid=1 want at most one");
    end
  end

endmodule
